// File: rtl/pwm_pkg.sv
// Shared defaults and mode encoding for the PWM generator and its channel comparators.
package pwm_pkg;

   localparam int unsigned N_CH_DEF       = 4;
   localparam int unsigned CNT_W_DEF      = 22;
   localparam int unsigned PERIOD_RST_DEF = 39999;

   typedef enum logic {
      MODE_EDGE   = 1'b0,
      MODE_CENTER = 1'b1
   } pwm_mode_e;

endpackage

// File: rtl/comparador_pwm.sv
// One PWM channel: active duty register, compare against the shared count, registered output.
module comparador_pwm
   import pwm_pkg::*;
#(
   parameter int unsigned      CNT_W    = CNT_W_DEF,
   parameter logic [CNT_W-1:0] DUTY_RST = '0
) (
   input  logic             clock_100Mhz,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             apply_i,
   input  logic [CNT_W-1:0] duty_sh_i,
   input  logic [CNT_W-1:0] cmp_val_i,
   output logic             senal_o
);

   logic [CNT_W-1:0] duty_q, duty_d;
   logic             senal_q, senal_d;

   always_comb begin
      duty_d  = apply_i ? duty_sh_i : duty_q;
      senal_d = en_i && (cmp_val_i < duty_q);
   end

   always_ff @(posedge clock_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         duty_q  <= DUTY_RST;
         senal_q <= 1'b0;
      end else begin
         duty_q  <= duty_d;
         senal_q <= senal_d;
      end
   end

   assign senal_o = senal_q;

endmodule

// File: rtl/generador_pwm.sv
// Multi-channel PWM generator: shared up / up-down counter, shadowed configuration
// applied only at period boundaries, one registered comparator per channel.
module generador_pwm
   import pwm_pkg::*;
#(
   parameter int unsigned N_CH       = N_CH_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned PERIOD_RST = PERIOD_RST_DEF
) (
   input  logic                  clock_100Mhz,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  load,
   input  logic [CNT_W-1:0]      period_in,
   input  logic [N_CH*CNT_W-1:0] duty_in,
   input  logic                  center_in,
   output logic [N_CH-1:0]       senal,
   output logic                  tick,
   output logic                  pending
);

   localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(PERIOD_RST);
   localparam logic [CNT_W-1:0] DUTY_INIT   = CNT_W'((PERIOD_RST + 1) / 2);
   localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             down_q, down_d;
   logic [CNT_W-1:0] period_q, period_sh_q;
   pwm_mode_e        center_q, center_sh_q;
   logic [CNT_W-1:0] duty_sh_q [N_CH];
   logic             pending_q, pending_d;
   logic             tick_q;
   logic             at_end, boundary, apply;
   logic [CNT_W-1:0] cnt_plus, cmp_val;

   assign cnt_plus = cnt_q + ONE;

   // Center mode marks the last cycle of a period as the down-phase cycle whose next count is 0.
   always_comb begin
      at_end = 1'b0;
      if (period_q == '0)
         at_end = 1'b1;
      else if (center_q == MODE_CENTER)
         at_end = down_q && (cnt_q == ONE);
      else
         at_end = (cnt_q == period_q);
   end

   assign boundary = enable && at_end;
   assign apply    = pending_q && (boundary || !enable);

   always_comb begin
      cnt_d     = cnt_q;
      down_d    = down_q;
      pending_d = load || (pending_q && !apply);
      if (!enable || boundary) begin
         cnt_d  = '0;
         down_d = 1'b0;
      end else if (center_q == MODE_CENTER) begin
         if (down_q) begin
            cnt_d = cnt_q - ONE;
         end else begin
            cnt_d  = cnt_plus;
            down_d = (cnt_plus == period_q);
         end
      end else begin
         cnt_d = cnt_plus;
      end
   end

   // Down-phase samples are shifted by one so each position repeats twice per
   // period: high time is 2*duty, centred on the valley.
   assign cmp_val = (center_q == MODE_CENTER && down_q) ? (cnt_q - ONE) : cnt_q;

   always_ff @(posedge clock_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         down_q      <= 1'b0;
         period_q    <= PERIOD_INIT;
         period_sh_q <= PERIOD_INIT;
         center_q    <= MODE_EDGE;
         center_sh_q <= MODE_EDGE;
         pending_q   <= 1'b0;
         tick_q      <= 1'b0;
         for (int i = 0; i < N_CH; i++) duty_sh_q[i] <= DUTY_INIT;
      end else begin
         cnt_q     <= cnt_d;
         down_q    <= down_d;
         pending_q <= pending_d;
         tick_q    <= boundary;
         if (apply) begin
            period_q <= period_sh_q;
            center_q <= center_sh_q;
         end
         if (load) begin
            period_sh_q <= period_in;
            center_sh_q <= pwm_mode_e'(center_in);
            for (int i = 0; i < N_CH; i++) duty_sh_q[i] <= duty_in[i*CNT_W +: CNT_W];
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      comparador_pwm #(
         .CNT_W    (CNT_W),
         .DUTY_RST (DUTY_INIT)
      ) u_cmp (
         .clock_100Mhz (clock_100Mhz),
         .rst_n        (rst_n),
         .en_i         (enable),
         .apply_i      (apply),
         .duty_sh_i    (duty_sh_q[g]),
         .cmp_val_i    (cmp_val),
         .senal_o      (senal[g])
      );
   end

   assign tick    = tick_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_generador_pwm.sv
// Directed bench for generador_pwm: table of configurations measured over one period each,
// plus hand sequences for reset waveform, load-on-boundary, enable gap and mid-period reset.
module tb_generador_pwm;

   localparam int CNT_W = 22;
   localparam int N_CH  = 4;

   logic                  clk;
   logic                  rst_n;
   logic                  enable;
   logic                  load;
   logic [CNT_W-1:0]      period_in;
   logic [N_CH*CNT_W-1:0] duty_in;
   logic                  center_in;
   logic [N_CH-1:0]       senal;
   logic                  tick;
   logic                  pending;

   generador_pwm dut (
      .clock_100Mhz (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .load         (load),
      .period_in    (period_in),
      .duty_in      (duty_in),
      .center_in    (center_in),
      .senal        (senal),
      .tick         (tick),
      .pending      (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic                  center;
      logic [CNT_W-1:0]      period;
      logic [3:0][CNT_W-1:0] duty;
      int                    len;
      logic [3:0][7:0]       hi;
      logic [15:0]           pat;
   } vec_t;

   vec_t vecs [7];
   int   checks   = 0;
   int   failures = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic c, input int p,
                          input int d0, input int d1, input int d2, input int d3,
                          input int ln, input int h0, input int h1, input int h2, input int h3,
                          input logic [15:0] pt);
      vecs[i].center  = c;
      vecs[i].period  = CNT_W'(p);
      vecs[i].duty[0] = CNT_W'(d0);
      vecs[i].duty[1] = CNT_W'(d1);
      vecs[i].duty[2] = CNT_W'(d2);
      vecs[i].duty[3] = CNT_W'(d3);
      vecs[i].len     = ln;
      vecs[i].hi[0]   = 8'(h0);
      vecs[i].hi[1]   = 8'(h1);
      vecs[i].hi[2]   = 8'(h2);
      vecs[i].hi[3]   = 8'(h3);
      vecs[i].pat     = pt;
   endtask

   task automatic put_inputs(input int i);
      period_in = vecs[i].period;
      duty_in   = vecs[i].duty;
      center_in = vecs[i].center;
   endtask

   task automatic drive_load(input int i);
      put_inputs(i);
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   // Counts samples from the first cycle of a period up to and including its tick.
   task automatic measure(input int i, input int pend_exp, input string tag);
      int          len;
      int          pend;
      int          hi [4];
      logic [15:0] pat;
      bit          done;
      len  = 0;
      pend = 0;
      pat  = '0;
      done = 0;
      for (int c = 0; c < 4; c++) hi[c] = 0;
      while (!done && len < 100) begin
         step();
         for (int c = 0; c < 4; c++) if (senal[c]) hi[c]++;
         if (len < 16 && senal[0]) pat[len] = 1'b1;
         if (pending) pend++;
         len++;
         if (tick) done = 1;
      end
      check({tag, "_len"}, len, vecs[i].len);
      for (int c = 0; c < 4; c++)
         check($sformatf("%s_hi%0d", tag, c), hi[c], 32'(vecs[i].hi[c]));
      check({tag, "_pat0"}, 32'(pat), 32'(vecs[i].pat));
      check({tag, "_pend"}, pend, pend_exp);
   endtask

   task automatic wait_pending_clear(input string tag);
      int n;
      n = 0;
      while (pending && n < 50000) begin
         step();
         n++;
      end
      check({tag, "_pend_clear"}, 32'(pending), 0);
      check({tag, "_tick_at_apply"}, 32'(tick), 1);
   endtask

   task automatic apply_vec(input int i);
      string tag;
      tag = $sformatf("vec%0d", i);
      drive_load(i);
      check({tag, "_pend_set"}, 32'(pending), 1);
      wait_pending_clear(tag);
      measure(i, 0, tag);
   endtask

   initial begin
      int hi_acc [4];
      int ticks;
      int bad;

      //      idx ctr per  d0 d1 d2 d3  len h0 h1 h2 h3  pattern ch0
      set_vec(0, 0,  9,   3, 0, 10, 5,  10, 3, 0, 10, 5, 16'h0007);
      set_vec(1, 1,  4,   2, 0, 4,  5,  8,  4, 0, 8,  8, 16'h00C3);
      set_vec(2, 0,  0,   0, 1, 2,  0,  1,  0, 1, 1,  0, 16'h0000);
      set_vec(3, 1,  1,   1, 0, 1,  2,  2,  2, 0, 2,  2, 16'h0003);
      set_vec(4, 0,  5,   5, 6, 1,  2,  6,  5, 6, 1,  2, 16'h001F);
      set_vec(5, 1,  3,   1, 2, 3,  0,  6,  2, 4, 6,  0, 16'h0021);
      set_vec(6, 1,  0,   0, 1, 0,  3,  1,  0, 1, 0,  1, 16'h0000);

      rst_n     = 1'b0;
      enable    = 1'b0;
      load      = 1'b0;
      period_in = '0;
      duty_in   = '0;
      center_in = 1'b0;
      step();
      step();
      check("rst_senal", 32'(senal), 0);
      check("rst_tick", 32'(tick), 0);
      check("rst_pending", 32'(pending), 0);

      // Reset waveform: 40000-cycle period, 20000 high; a mid-period load waits for the boundary.
      @(negedge clk);
      rst_n  = 1'b1;
      enable = 1'b1;
      for (int c = 0; c < 4; c++) hi_acc[c] = 0;
      ticks = 0;
      for (int s = 1; s <= 40000; s++) begin
         if (s == 25000) begin
            put_inputs(0);
            load = 1'b1;
         end
         step();
         if (s == 1) check("rst_first_count", 32'(senal), 32'hF);
         if (s == 25000) begin
            load = 1'b0;
            check("rst_wave_pend_set", 32'(pending), 1);
         end
         if (s == 39999) check("rst_wave_pend_hold", 32'(pending), 1);
         for (int c = 0; c < 4; c++) if (senal[c]) hi_acc[c]++;
         if (tick) ticks++;
         if (s == 40000) begin
            check("rst_wave_last_tick", 32'(tick), 1);
            check("rst_wave_pend_clear", 32'(pending), 0);
         end
      end
      for (int c = 0; c < 4; c++) check($sformatf("rst_wave_hi%0d", c), hi_acc[c], 20000);
      check("rst_wave_ticks", ticks, 1);
      measure(0, 0, "vec0_first");

      for (int i = 1; i < 7; i++) apply_vec(i);

      // Load landing exactly on a boundary: old shadow (vec4) applies, new (vec1) follows.
      apply_vec(0);
      drive_load(4);
      check("lob_pend_a", 32'(pending), 1);
      for (int k = 0; k < 8; k++) step();
      put_inputs(1);
      load = 1'b1;
      step();
      load = 1'b0;
      check("lob_tick", 32'(tick), 1);
      check("lob_pend_kept", 32'(pending), 1);
      measure(4, 5, "lob_old");
      measure(1, 0, "lob_new");

      // Enable gap of 50 cycles mid-period, then a full period from cnt 0.
      step();
      step();
      step();
      enable = 1'b0;
      bad = 0;
      for (int k = 0; k < 50; k++) begin
         step();
         if (senal !== 4'h0 || tick !== 1'b0) bad++;
      end
      check("dis_quiet", bad, 0);
      enable = 1'b1;
      measure(1, 0, "reen");

      // Reset while a shadow is pending: outputs drop immediately, reset waveform resumes.
      drive_load(0);
      check("rstmid_pend_set", 32'(pending), 1);
      step();
      step();
      #3;
      rst_n = 1'b0;
      #1;
      check("rstmid_senal", 32'(senal), 0);
      check("rstmid_tick", 32'(tick), 0);
      check("rstmid_pending", 32'(pending), 0);
      step();
      check("rstmid_hold_senal", 32'(senal), 0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         step();
         if (senal !== 4'hF || tick !== 1'b0 || pending !== 1'b0) bad++;
      end
      check("rstmid_resume", bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/generador_pwm.md
GENERADOR_PWM -- requirements
Module: generador_pwm

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of independent PWM channels.
REQ-002 SHALL have parameter CNT_W, default 22, meaning counter, period and duty width in bits.
REQ-003 SHALL have parameter PERIOD_RST, default 39999, meaning reset period value (2.5 kHz edge-aligned at 100 MHz).
REQ-004 SHALL use one clock and an asynchronous, active-low reset, named as follows.
REQ-005 SHALL have port clock_100Mhz, input, 1, meaning system clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, meaning run counter when 1, hold when 0.
REQ-008 SHALL have port load, input, 1, meaning single-cycle strobe that captures the configuration inputs into the shadow registers.
REQ-009 SHALL have port period_in, input, CNT_W, meaning requested period value.
REQ-010 SHALL have port duty_in, input, N_CH*CNT_W, meaning requested duty per channel; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-011 SHALL have port center_in, input, 1, meaning requested mode: 0 edge-aligned, 1 center-aligned.
REQ-012 SHALL have port senal, output, N_CH, meaning registered PWM outputs.
REQ-013 SHALL have port tick, output, 1, meaning one-cycle pulse at each period boundary.
REQ-014 SHALL have port pending, output, 1, meaning shadow configuration not yet applied.

Function
REQ-015 SHALL keep active registers period_q, duty_q[N_CH] and center_q, and shadow copies of each; the counter and comparators use only the active registers.
REQ-016 On load=1, SHALL capture period_in, duty_in and center_in into the shadow registers and set pending=1 on the next edge.
REQ-017 Edge mode: counter SHALL count 0..period_q, then wrap to 0; the boundary is the cycle with cnt==period_q; the period is period_q+1 cycles.
REQ-018 Center mode: counter SHALL count up 0..period_q, then down to 0; the boundary is cnt==0 while counting down; the period is 2*period_q cycles.
REQ-019 At a boundary with pending=1, SHALL copy shadow to active, clear pending, and restart the counter at 0 counting up.
REQ-020 If load and a boundary coincide, SHALL transfer the pre-existing shadow, capture the new values into the shadow, and leave pending=1.
REQ-021 SHALL register senal[i] = (cnt < duty_q[i]), giving 1-cycle latency from the counter.
REQ-022 duty_q[i]==0 SHALL give constant 0; duty_q[i]>period_q SHALL give constant 1 in edge mode (>= period_q in center mode).
REQ-023 period_q==0 SHALL make every enabled cycle a boundary, with the counter held at 0.
REQ-024 SHALL register tick high for exactly one cycle per boundary, aligned with senal timing, regardless of pending.
REQ-025 While enable=0, SHALL hold cnt=0 with direction up, drive senal=0 and tick=0, and apply any pending shadow on the next edge.
REQ-026 When enable rises, SHALL start counting from 0 on the following edge.
REQ-027 All arithmetic SHALL be unsigned CNT_W-bit, and the counter SHALL never exceed period_q.

Reset
REQ-028 When rst_n=0, SHALL asynchronously set: cnt=0, direction up, period_q and period shadow = PERIOD_RST, all duty_q and duty shadows = (PERIOD_RST+1)/2, center_q and center shadow = 0, senal=0, tick=0, pending=0.
REQ-029 Reset asserted mid-period SHALL discard any pending shadow, and outputs SHALL be at reset values while rst_n=0.
REQ-030 After rst_n deasserts with enable=1, the first count edge SHALL be the first rising edge after deassertion.

Structure
REQ-031 SHALL place CNT_W/N_CH defaults, PERIOD_RST and the mode encoding (EDGE=0, CENTER=1) in shared package pwm_pkg.
REQ-032 SHALL instantiate per-channel sub-module comparador_pwm (duty register, compare, output flop) N_CH times via generate; counter and shadow logic remain in the top.

Verification
REQ-033 Reset, then enable=1 with no load -> every senal[i] toggles with period 40000 cycles and 20000 high; tick once per 40000 cycles.
REQ-034 Mid-period load with period_in=9, duty ch0=3, ch1=0, ch2=10, ch3=5 -> pending=1 until the next boundary, then period 10 cycles: ch0 3 high, ch1 always low, ch2 always high, ch3 5 high; pending=0.
REQ-035 Load with center_in=1, period_in=4, duty=2 -> after the boundary, cnt sequence 0,1,2,3,4,3,2,1,0..., period 8, senal high 4 cycles centered on the valley.
REQ-036 load pulsed exactly on a boundary cycle -> old shadow is applied, the new values are applied at the next boundary, and pending stays 1 between the two.
REQ-037 rst_n pulsed low mid-period while pending=1 -> immediately senal=0, tick=0, pending=0; the PERIOD_RST waveform resumes from cnt 0.
REQ-038 enable=0 for 50 cycles mid-period -> senal=0, no tick; on re-enable, a full period starts at cnt 0.
